// File: rtl/s2axi_pkg.sv
// Shared types, AXI constants and elaboration-time helpers for the stream-to-AXI burst writer.
package s2axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // AXI awsize is log2 of the bytes per beat.
   function automatic logic [2:0] size_enc(input int data_w);
      return 3'(clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/s2axi_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and synchronous flush.
module s2axi_fifo
   import s2axi_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int FIFO_AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [FIFO_AW:0]  count
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               do_wr;
   logic               do_rd;

   assign full    = (count == (FIFO_AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; pointers and count define validity,
   // and an unreset array can map onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/s2axi_burst_writer.sv
// Stream-to-AXI3 INCR burst writer into an OCM ring buffer.
// Optional write-response checking is enabled by defining S2AXI_BRESP_CHECK_EN.
module s2axi_burst_writer
   import s2axi_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          BURST_LEN = 16,
   parameter int          FIFO_AW   = 6,
   parameter logic [31:0] OCM_BASE  = 32'hfffc0000,
   parameter int          OCM_WIDTH = 16,
   parameter logic [11:0] AXI_ID    = 12'hfff
) (
   input  logic                AXI_clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   Sin,
   input  logic                Ien,
   input  logic                sync,
   output logic [31:0]         AXI_awaddr,
   output logic                AXI_awvalid,
   input  logic                AXI_awready,
   output logic [3:0]          AXI_awlen,
   output logic [2:0]          AXI_awsize,
   output logic [1:0]          AXI_awburst,
   output logic [11:0]         AXI_awid,
   output logic [DATA_W-1:0]   AXI_wdata,
   output logic [DATA_W/8-1:0] AXI_wstrb,
   output logic [11:0]         AXI_wid,
   output logic                AXI_wvalid,
   output logic                AXI_wlast,
   input  logic                AXI_wready,
   input  logic                AXI_bvalid,
   input  logic [1:0]          AXI_bresp,
   output logic                AXI_bready,
   output logic [31:0]         burst_cnt,
   output logic [15:0]         drop_cnt,
`ifdef S2AXI_BRESP_CHECK_EN
   output logic                bresp_err,
   output logic [31:0]         err_addr,
`endif
   output logic                ovf
);

   localparam int                BEAT_W      = clog2(BURST_LEN);
   localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * DATA_W / 8);
   localparam logic [31:0]       RING_MASK   = (32'd1 << OCM_WIDTH) - 32'd1;
   localparam logic [FIFO_AW:0]  BURST_FILL  = (FIFO_AW + 1)'(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

   state_t              state;
   state_t              state_nxt;
   logic                sync_pend;
   logic                sync_apply;
   logic                accept_ok;
   logic                w_hs;
   logic                b_hs;
   logic                fifo_full;
   logic                fifo_empty;
   logic [FIFO_AW:0]    fifo_count;
   logic [DATA_W-1:0]   fifo_head;
   logic [BEAT_W-1:0]   beat;

   // A sync seen outside IDLE is parked and takes effect on the next IDLE cycle.
   assign sync_apply = (state == ST_IDLE) && (sync || sync_pend);
   assign accept_ok  = Ien && !sync && !sync_pend;
   assign w_hs       = AXI_wvalid && AXI_wready;
   assign b_hs       = AXI_bvalid && AXI_bready;

   s2axi_fifo #(
      .DATA_W  (DATA_W),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk     (AXI_clk),
      .rst     (rst),
      .flush   (sync_apply),
      .wr_en   (accept_ok),
      .wr_data (Sin),
      .rd_en   (w_hs),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign AXI_awlen   = 4'(BURST_LEN - 1);
   assign AXI_awsize  = size_enc(DATA_W);
   assign AXI_awburst = BURST_INCR;
   assign AXI_awid    = AXI_ID;
   assign AXI_wid     = AXI_ID;
   assign AXI_wstrb   = '1;
   assign AXI_wdata   = fifo_head;
   assign AXI_wlast   = (state == ST_DATA) && (beat == LAST_BEAT);

   // NOTE: every output of this block gets a default before the case, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      AXI_awvalid = 1'b0;
      AXI_wvalid  = 1'b0;
      AXI_bready  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!sync_apply && (fifo_count >= BURST_FILL)) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            AXI_awvalid = 1'b1;
            if (AXI_awready) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            AXI_wvalid = !fifo_empty;
            if (!fifo_empty && AXI_wready && (beat == LAST_BEAT)) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            AXI_bready = 1'b1;
            if (AXI_bvalid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge AXI_clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         beat       <= '0;
         sync_pend  <= 1'b0;
         AXI_awaddr <= OCM_BASE;
         burst_cnt  <= '0;
         drop_cnt   <= '0;
         ovf        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (w_hs) beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);

         if (sync_apply)  sync_pend <= 1'b0;
         else if (sync)   sync_pend <= 1'b1;

         if (sync_apply) begin
            AXI_awaddr <= OCM_BASE;
            burst_cnt  <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
         end else begin
            // Low OCM_WIDTH bits wrap inside the ring; upper bits stay pinned to the base.
            if (b_hs) begin
               AXI_awaddr <= (OCM_BASE & ~RING_MASK) | ((AXI_awaddr + BURST_BYTES) & RING_MASK);
               burst_cnt  <= burst_cnt + 32'd1;
            end
            if (accept_ok && fifo_full) begin
               ovf <= 1'b1;
               if (drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
            end
         end
      end
   end

`ifdef S2AXI_BRESP_CHECK_EN
   // Only the first failing burst address is kept until the flag is cleared.
   always_ff @(posedge AXI_clk) begin
      if (rst || sync_apply) begin
         bresp_err <= 1'b0;
         err_addr  <= '0;
      end else if (b_hs && (AXI_bresp != RESP_OKAY) && !bresp_err) begin
         bresp_err <= 1'b1;
         err_addr  <= AXI_awaddr;
      end
   end
`else
   logic unused_bresp;
   assign unused_bresp = ^AXI_bresp;
`endif

endmodule

// File: tb/tb_s2axi_burst_writer.sv
// Scoreboard bench for s2axi_burst_writer: expected addresses/data queued at stimulus, popped per AXI handshake.
module tb_s2axi_burst_writer;

   localparam int          DATA_W    = 32;
   localparam int          BURST_LEN = 16;
   localparam int          FIFO_AW   = 6;
   localparam int          OCM_WIDTH = 8;
   localparam logic [31:0] OCM_BASE  = 32'hfffc0000;

   logic        AXI_clk;
   logic        rst;
   logic [31:0] Sin;
   logic        Ien;
   logic        sync;
   logic [31:0] AXI_awaddr;
   logic        AXI_awvalid;
   logic        AXI_awready;
   logic [3:0]  AXI_awlen;
   logic [2:0]  AXI_awsize;
   logic [1:0]  AXI_awburst;
   logic [11:0] AXI_awid;
   logic [31:0] AXI_wdata;
   logic [3:0]  AXI_wstrb;
   logic [11:0] AXI_wid;
   logic        AXI_wvalid;
   logic        AXI_wlast;
   logic        AXI_wready;
   logic        AXI_bvalid;
   logic [1:0]  AXI_bresp;
   logic        AXI_bready;
   logic [31:0] burst_cnt;
   logic [15:0] drop_cnt;
   logic        ovf;
`ifdef S2AXI_BRESP_CHECK_EN
   logic        bresp_err;
   logic [31:0] err_addr;
`endif

   s2axi_burst_writer #(
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN),
      .FIFO_AW   (FIFO_AW),
      .OCM_BASE  (OCM_BASE),
      .OCM_WIDTH (OCM_WIDTH),
      .AXI_ID    (12'hfff)
   ) dut (
      .AXI_clk     (AXI_clk),
      .rst         (rst),
      .Sin         (Sin),
      .Ien         (Ien),
      .sync        (sync),
      .AXI_awaddr  (AXI_awaddr),
      .AXI_awvalid (AXI_awvalid),
      .AXI_awready (AXI_awready),
      .AXI_awlen   (AXI_awlen),
      .AXI_awsize  (AXI_awsize),
      .AXI_awburst (AXI_awburst),
      .AXI_awid    (AXI_awid),
      .AXI_wdata   (AXI_wdata),
      .AXI_wstrb   (AXI_wstrb),
      .AXI_wid     (AXI_wid),
      .AXI_wvalid  (AXI_wvalid),
      .AXI_wlast   (AXI_wlast),
      .AXI_wready  (AXI_wready),
      .AXI_bvalid  (AXI_bvalid),
      .AXI_bresp   (AXI_bresp),
      .AXI_bready  (AXI_bready),
      .burst_cnt   (burst_cnt),
      .drop_cnt    (drop_cnt),
`ifdef S2AXI_BRESP_CHECK_EN
      .bresp_err   (bresp_err),
      .err_addr    (err_addr),
`endif
      .ovf         (ovf)
   );

   initial AXI_clk = 1'b0;
   always #5 AXI_clk = ~AXI_clk;

   int          n_cmp;
   int          n_bad;
   logic [31:0] exp_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] mon_exp;
   logic [31:0] seq;
   int          beat_idx;
   int          b_seen;
   int          err_burst;
   logic [1:0]  aw_cfg;     // 0 = low, 1 = high, 2 = random
   logic [1:0]  w_cfg;
   logic        prev_aw_stall;
   logic        prev_w_stall;
   logic [31:0] prev_awaddr;
   logic [31:0] prev_wdata;

   // Ready/response driver, updated just after each rising edge.
   always @(posedge AXI_clk) begin
      #1;
      AXI_awready = (aw_cfg == 2'd2) ? 1'($urandom_range(0, 1)) : aw_cfg[0];
      AXI_wready  = (w_cfg == 2'd2) ? 1'($urandom_range(0, 1)) : w_cfg[0];
      AXI_bvalid  = 1'b1;
      AXI_bresp   = (b_seen == err_burst) ? 2'b10 : 2'b00;
   end

   // Handshake monitor on the falling edge: stability, address and data scoreboard.
   always @(negedge AXI_clk) begin
      if (rst) begin
         prev_aw_stall = 1'b0;
         prev_w_stall  = 1'b0;
         beat_idx      = 0;
         b_seen        = 0;
         exp_data.delete();
         exp_addr.delete();
      end else begin
         if (prev_aw_stall) begin
            n_cmp++;
            if (!AXI_awvalid || AXI_awaddr !== prev_awaddr) begin
               n_bad++;
               $display("FAIL aw_stable: awvalid=%b awaddr=%h required 1/%h", AXI_awvalid, AXI_awaddr, prev_awaddr);
            end
         end
         if (prev_w_stall) begin
            n_cmp++;
            if (!AXI_wvalid || AXI_wdata !== prev_wdata) begin
               n_bad++;
               $display("FAIL w_stable: wvalid=%b wdata=%h required 1/%h", AXI_wvalid, AXI_wdata, prev_wdata);
            end
         end
         if (AXI_awvalid && AXI_awready) begin
            n_cmp++;
            if (exp_addr.size() == 0) begin
               n_bad++;
               $display("FAIL aw_unexpected: awaddr=%h with no burst expected", AXI_awaddr);
            end else begin
               mon_exp = exp_addr.pop_front();
               if (AXI_awaddr !== mon_exp) begin
                  n_bad++;
                  $display("FAIL awaddr: got %h required %h", AXI_awaddr, mon_exp);
               end
            end
         end
         if (AXI_wvalid && AXI_wready) begin
            n_cmp++;
            if (exp_data.size() == 0) begin
               n_bad++;
               $display("FAIL w_unexpected: wdata=%h with no data expected", AXI_wdata);
            end else begin
               mon_exp = exp_data.pop_front();
               if (AXI_wdata !== mon_exp) begin
                  n_bad++;
                  $display("FAIL wdata: beat %0d got %h required %h", beat_idx, AXI_wdata, mon_exp);
               end
            end
            n_cmp++;
            if (AXI_wlast !== ((beat_idx % BURST_LEN) == BURST_LEN - 1)) begin
               n_bad++;
               $display("FAIL wlast: beat %0d got %b", beat_idx, AXI_wlast);
            end
            beat_idx++;
         end
         if (AXI_bvalid && AXI_bready) b_seen++;
         prev_aw_stall = AXI_awvalid && !AXI_awready;
         prev_w_stall  = AXI_wvalid && !AXI_wready;
         prev_awaddr   = AXI_awaddr;
         prev_wdata    = AXI_wdata;
      end
   end

   task automatic tick();
      @(posedge AXI_clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      Ien       = 1'b0;
      sync      = 1'b0;
      Sin       = '0;
      aw_cfg    = 2'd1;
      w_cfg     = 2'd1;
      err_burst = -1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // Drives n consecutive samples; the first n_keep are expected to reach AXI.
   task automatic send(input int n, input int n_keep);
      for (int i = 0; i < n; i++) begin
         tick();
         Ien = 1'b1;
         Sin = seq;
         if (i < n_keep) exp_data.push_back(seq);
         seq++;
      end
      tick();
      Ien = 1'b0;
   endtask

   task automatic wait_bursts(input logic [31:0] target, input int budget);
      int c;
      c = 0;
      while (burst_cnt !== target && c < budget) begin
         @(negedge AXI_clk);
         c++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge AXI_clk);
      n_cmp++;
      if ({AXI_awvalid, AXI_wvalid, AXI_bready, ovf} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags: aw/w/b/ovf=%b required 0000", {AXI_awvalid, AXI_wvalid, AXI_bready, ovf});
      end
      n_cmp++;
      if (AXI_awaddr !== OCM_BASE || burst_cnt !== 0 || drop_cnt !== 0) begin
         n_bad++;
         $display("FAIL reset_regs: awaddr=%h burst=%0d drop=%0d required %h/0/0", AXI_awaddr, burst_cnt, drop_cnt, OCM_BASE);
      end
      n_cmp++;
      if ({AXI_awlen, AXI_awsize, AXI_awburst, AXI_awid, AXI_wid, AXI_wstrb} !== {4'hf, 3'd2, 2'b01, 12'hfff, 12'hfff, 4'hf}) begin
         n_bad++;
         $display("FAIL constants: len=%h size=%h burst=%b awid=%h wid=%h strb=%h", AXI_awlen, AXI_awsize, AXI_awburst, AXI_awid, AXI_wid, AXI_wstrb);
      end
`ifdef S2AXI_BRESP_CHECK_EN
      n_cmp++;
      if (bresp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_bresp_err: got %b required 0", bresp_err);
      end
`endif
      // Stall a burst in its data phase, then reset it away.
      w_cfg = 2'd0;
      exp_addr.push_back(OCM_BASE);
      send(20, 0);
      repeat (4) @(negedge AXI_clk);
      n_cmp++;
      if (AXI_wvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL stuck_in_data: wvalid=%b required 1", AXI_wvalid);
      end
      tick();
      rst = 1'b1;
      tick();
      @(negedge AXI_clk);
      n_cmp++;
      if ({AXI_awvalid, AXI_wvalid, AXI_bready} !== 3'b000 || AXI_awaddr !== OCM_BASE) begin
         n_bad++;
         $display("FAIL mid_burst_reset: aw/w/b=%b awaddr=%h required 000/%h", {AXI_awvalid, AXI_wvalid, AXI_bready}, AXI_awaddr, OCM_BASE);
      end
   endtask

   task automatic test_basic();
      do_reset();
      exp_addr.push_back(OCM_BASE);
      exp_addr.push_back(OCM_BASE + 32'h40);
      send(40, 40);
      wait_bursts(2, 300);
      repeat (30) @(negedge AXI_clk);
      n_cmp++;
      if (burst_cnt !== 32'd2 || AXI_awvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_bursts: burst_cnt=%0d awvalid=%b required 2/0", burst_cnt, AXI_awvalid);
      end
      n_cmp++;
      if (exp_data.size() != 8) begin
         n_bad++;
         $display("FAIL basic_residue: %0d words unsent, required 8", exp_data.size());
      end
      exp_addr.push_back(OCM_BASE + 32'h80);
      send(8, 8);
      wait_bursts(3, 200);
      n_cmp++;
      if (burst_cnt !== 32'd3 || exp_data.size() != 0 || exp_addr.size() != 0) begin
         n_bad++;
         $display("FAIL basic_drain: burst_cnt=%0d data_left=%0d addr_left=%0d required 3/0/0", burst_cnt, exp_data.size(), exp_addr.size());
      end
   endtask

   task automatic test_ring_wrap();
      do_reset();
      for (int i = 0; i < 5; i++) exp_addr.push_back(OCM_BASE | ((32'(i) * 32'h40) & 32'hff));
      send(80, 80);
      wait_bursts(5, 600);
      @(negedge AXI_clk);
      n_cmp++;
      if (burst_cnt !== 32'd5 || AXI_awaddr !== 32'hfffc0040) begin
         n_bad++;
         $display("FAIL ring_wrap: burst_cnt=%0d awaddr=%h required 5/fffc0040", burst_cnt, AXI_awaddr);
      end
      n_cmp++;
      if (exp_data.size() != 0 || exp_addr.size() != 0) begin
         n_bad++;
         $display("FAIL ring_drain: data_left=%0d addr_left=%0d required 0/0", exp_data.size(), exp_addr.size());
      end
   endtask

   task automatic test_stalls();
      do_reset();
      aw_cfg = 2'd2;
      w_cfg  = 2'd2;
      for (int i = 0; i < 3; i++) exp_addr.push_back(OCM_BASE + 32'(i) * 32'h40);
      send(48, 48);
      wait_bursts(3, 3000);
      n_cmp++;
      if (burst_cnt !== 32'd3 || exp_data.size() != 0 || exp_addr.size() != 0) begin
         n_bad++;
         $display("FAIL stalls: burst_cnt=%0d data_left=%0d addr_left=%0d required 3/0/0", burst_cnt, exp_data.size(), exp_addr.size());
      end
      aw_cfg = 2'd1;
      w_cfg  = 2'd1;
   endtask

   task automatic test_overflow();
      do_reset();
      w_cfg = 2'd0;
      for (int i = 0; i < 4; i++) exp_addr.push_back(OCM_BASE + 32'(i) * 32'h40);
      send(100, 64);
      @(negedge AXI_clk);
      n_cmp++;
      if (ovf !== 1'b1 || drop_cnt !== 16'd36) begin
         n_bad++;
         $display("FAIL overflow: ovf=%b drop_cnt=%0d required 1/36", ovf, drop_cnt);
      end
      w_cfg = 2'd1;
      wait_bursts(4, 600);
      n_cmp++;
      if (burst_cnt !== 32'd4 || ovf !== 1'b1 || exp_data.size() != 0) begin
         n_bad++;
         $display("FAIL overflow_drain: burst_cnt=%0d ovf=%b data_left=%0d required 4/1/0", burst_cnt, ovf, exp_data.size());
      end
   endtask

   task automatic test_sync();
      int c;
      do_reset();
      w_cfg = 2'd0;
      exp_addr.push_back(OCM_BASE);
      exp_addr.push_back(OCM_BASE + 32'h40);
      send(70, 32);
      @(negedge AXI_clk);
      n_cmp++;
      if (ovf !== 1'b1 || drop_cnt !== 16'd6) begin
         n_bad++;
         $display("FAIL sync_pre_ovf: ovf=%b drop_cnt=%0d required 1/6", ovf, drop_cnt);
      end
      w_cfg = 2'd1;
      wait_bursts(1, 300);
      c = 0;
      while (!AXI_wvalid && c < 50) begin
         @(negedge AXI_clk);
         c++;
      end
      n_cmp++;
      if (AXI_wvalid !== 1'b1 || burst_cnt !== 32'd1) begin
         n_bad++;
         $display("FAIL sync_in_data: wvalid=%b burst_cnt=%0d required 1/1", AXI_wvalid, burst_cnt);
      end
      tick();
      sync = 1'b1;
      Ien  = 1'b1;
      tick();
      sync = 1'b0;
      repeat (3) tick();
      Ien = 1'b0;
      repeat (40) @(negedge AXI_clk);
      n_cmp++;
      if (burst_cnt !== 32'd0 || ovf !== 1'b0 || drop_cnt !== 16'd0 || AXI_awaddr !== OCM_BASE) begin
         n_bad++;
         $display("FAIL sync_applied: burst_cnt=%0d ovf=%b drop=%0d awaddr=%h required 0/0/0/%h", burst_cnt, ovf, drop_cnt, AXI_awaddr, OCM_BASE);
      end
      n_cmp++;
      if (AXI_awvalid !== 1'b0 || exp_data.size() != 0 || exp_addr.size() != 0) begin
         n_bad++;
         $display("FAIL sync_flush: awvalid=%b data_left=%0d addr_left=%0d required 0/0/0", AXI_awvalid, exp_data.size(), exp_addr.size());
      end
      exp_addr.push_back(OCM_BASE);
      send(16, 16);
      wait_bursts(1, 200);
      @(negedge AXI_clk);
      n_cmp++;
      if (burst_cnt !== 32'd1 || AXI_awaddr !== OCM_BASE + 32'h40 || exp_data.size() != 0) begin
         n_bad++;
         $display("FAIL sync_restart: burst_cnt=%0d awaddr=%h data_left=%0d required 1/%h/0", burst_cnt, AXI_awaddr, exp_data.size(), OCM_BASE + 32'h40);
      end
   endtask

`ifdef S2AXI_BRESP_CHECK_EN
   task automatic test_bresp();
      do_reset();
      err_burst = 2;
      for (int i = 0; i < 4; i++) exp_addr.push_back(OCM_BASE + 32'(i) * 32'h40);
      send(64, 64);
      wait_bursts(4, 600);
      @(negedge AXI_clk);
      n_cmp++;
      if (bresp_err !== 1'b1 || err_addr !== 32'hfffc0080) begin
         n_bad++;
         $display("FAIL bresp_err: flag=%b err_addr=%h required 1/fffc0080", bresp_err, err_addr);
      end
      n_cmp++;
      if (burst_cnt !== 32'd4 || AXI_awaddr !== OCM_BASE || exp_data.size() != 0) begin
         n_bad++;
         $display("FAIL bresp_continue: burst_cnt=%0d awaddr=%h data_left=%0d required 4/%h/0", burst_cnt, AXI_awaddr, exp_data.size(), OCM_BASE);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      seq       = 32'ha5000000;
      rst       = 1'b1;
      Ien       = 1'b0;
      sync      = 1'b0;
      Sin       = '0;
      aw_cfg    = 2'd1;
      w_cfg     = 2'd1;
      err_burst = -1;
      test_reset();
      test_basic();
      test_ring_wrap();
      test_stalls();
      test_overflow();
      test_sync();
`ifdef S2AXI_BRESP_CHECK_EN
      test_bresp();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/s2axi_burst_writer.md
Name: s2axi_burst_writer

Overview:
- Parametrised successor to the stream-to-AXI write path: accepts a sample stream (Sin/Ien) on the AXI clock, buffers it in an internal FIFO, and issues AXI3 INCR write bursts into an OCM ring buffer.
- Generalised over data width, burst length, FIFO depth and ring size. Adds overflow detection, deferred sync, burst/drop counters and write-response checking, none of which the previous bridge had.
- Sits between the sample front-end, once it is resynchronised to AXI_clk, and the Zynq HP/ACP slave port.

Parameters:
DATA_W, 32, stream and AXI data width; 32 or 64 only
BURST_LEN, 16, beats per burst; 2..16 (AXI3 awlen limit)
FIFO_AW, 6, log2 FIFO depth; depth must be >= 2*BURST_LEN
OCM_BASE, 32'hfffc0000, ring base byte address; aligned to 2^OCM_WIDTH
OCM_WIDTH, 16, log2 ring size in bytes; ring size must be a multiple of the burst size in bytes
AXI_ID, 12'hfff, constant awid/wid

Ports:
AXI_clk  in  1  single clock for the whole block
rst  in  1  synchronous, active-high reset
Sin  in  DATA_W  stream sample
Ien  in  1  Sin valid this cycle; there is no backpressure
sync  in  1  one-cycle pulse; restarts the ring at OCM_BASE
AXI_awaddr  out  32  burst start address
AXI_awvalid  out  1  address valid
AXI_awready  in  1  address accepted
AXI_awlen  out  4  constant BURST_LEN-1
AXI_awsize  out  3  constant log2(DATA_W/8)
AXI_awburst  out  2  constant 2'b01 (INCR)
AXI_awid  out  12  constant AXI_ID
AXI_wdata  out  DATA_W  write data
AXI_wstrb  out  DATA_W/8  constant all ones
AXI_wid  out  12  constant AXI_ID
AXI_wvalid  out  1  write data valid
AXI_wlast  out  1  final beat of the burst
AXI_wready  in  1  data accepted
AXI_bvalid  in  1  write response valid
AXI_bresp  in  2  write response code
AXI_bready  out  1  response ready
burst_cnt  out  32  completed bursts since reset or sync
drop_cnt  out  16  samples dropped; saturates at 16'hffff
ovf  out  1  sticky overflow flag; cleared by rst or by an applied sync

Behaviour:
- Reset: all valid/ready outputs 0; AXI_awaddr = OCM_BASE; counters 0; ovf 0; FIFO empty; FSM in IDLE.
- FIFO is first-word-fall-through, 2^FIFO_AW entries, with a FIFO_AW+1 bit occupancy count.
  - Ien && !full: Sin written.
  - Ien && full: sample discarded, ovf set, drop_cnt incremented.
  - A write and a read in the same cycle are both legal. A write while full is dropped even if a read happens that cycle.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE -> ADDR when occupancy >= BURST_LEN and no sync is pending. AXI_awvalid rises on the next cycle.
- ADDR: AXI_awvalid held at 1 with a stable address until AXI_awready; then -> DATA.
- DATA:
  - AXI_wvalid = 1. AXI_wdata is the FIFO head.
  - A beat pops on AXI_wvalid && AXI_wready.
  - A beat counter of width clog2(BURST_LEN) drives AXI_wlast high on beat BURST_LEN-1.
  - When the last beat is accepted -> RESP.
  - The FIFO never underflows, because BURST_LEN words were guaranteed at entry.
- RESP: AXI_bready = 1. On AXI_bvalid -> IDLE.
  - In the same cycle, burst_cnt increments and the address advances by BURST_LEN*DATA_W/8.
  - Address arithmetic is modulo 2^OCM_WIDTH: the low OCM_WIDTH bits wrap and the upper bits are held at OCM_BASE.
- Throughput: one burst outstanding at a time; minimum IDLE-to-IDLE time is BURST_LEN+3 cycles.
- sync handling:
  - In IDLE, sync is applied in the same cycle: FIFO flushed, address = OCM_BASE, burst_cnt = 0, ovf = 0, drop_cnt = 0.
  - In any other state, sync sets sync_pend. The current burst completes normally, and sync is applied on the return to IDLE.
  - While sync_pend = 1, Ien samples are discarded but not counted as drops.
  - Ien in the same cycle as an applied sync is discarded.
- rst mid-burst: the FSM aborts to IDLE immediately. The system-level reset also resets the interconnect, so no protocol completion is attempted.

Optional Feature:
S2AXI_BRESP_CHECK_EN
- Defined:
  - Adds output bresp_err (1 bit, sticky, reset 0, cleared by an applied sync), set when AXI_bvalid && AXI_bresp != 2'b00.
  - Adds output err_addr (32 bit), capturing AXI_awaddr of the first failing burst.
  - A failing burst still advances the address and burst_cnt.
- Undefined: AXI_bresp is ignored, and neither port exists.

Decomposition:
- Package s2axi_pkg holds:
  - FSM state enum;
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00;
  - a clog2 function;
  - the size-encode function that maps DATA_W to awsize.
- Sub-module s2axi_fifo: single-clock FWFT FIFO parametrised by DATA_W/FIFO_AW, with full/empty/count/flush ports.

Test Plan:
- 40 samples on Ien, DATA_W=32, BURST_LEN=16, awready/wready/bvalid always 1 -> 2 bursts at fffc0000 and fffc0040; wlast on beats 15 and 31; 8 words remain; burst_cnt = 2.
- Ring wrap with OCM_WIDTH=8: 5 bursts -> addresses 00, 40, 80, c0, then 00 (upper bits fffc00); burst_cnt = 5.
- Random awready/wready stalls (50%) -> awaddr, awvalid and wdata stable while stalled; data order matches the input sequence exactly.
- Hold wready=0 with FIFO_AW=6 while streaming 100 samples -> ovf = 1, drop_cnt = 100 - 64 - beats already popped; accepted data stays uncorrupted.
- sync pulse during the DATA state of burst 2 -> burst 2 completes at fffc0040; next burst at fffc0000; burst_cnt and ovf reset after the RESP state.
- With S2AXI_BRESP_CHECK_EN defined, bresp = 2'b10 on burst 3 -> bresp_err = 1, err_addr = fffc0080; bursts continue.
